// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the mem_lsu memory-access stage.
// Holds LSU state encodings, funct3 size codes and bus widths.
package mem_lsu_pkg;

    localparam int DATA_W  = 64;
    localparam int REG_IDX_W = 5;
    localparam int MASK_W  = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_e;

    // Byte strobes for the access size; lanes past 7 fall off the top.
    function automatic logic [MASK_W-1:0] size_mask(
        input logic [2:0] funct3,
        input logic [2:0] off
    );
        logic [MASK_W-1:0] base;
        unique case (funct3[1:0])
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            2'b10:   base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    function automatic logic is_misaligned(
        input logic [2:0] funct3,
        input logic [2:0] off
    );
        logic bad;
        unique case (funct3[1:0])
            2'b00:   bad = 1'b0;
            2'b01:   bad = off[0];
            2'b10:   bad = |off[1:0];
            default: bad = |off;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory bus: single-outstanding req/gnt/rvalid handshake.
// master = LSU side, slave = memory side.
interface mem_lsu_if;
    import mem_lsu_pkg::*;

    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata, wmask,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wmask,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/mem_lsu_ldext.sv
// Load data lane select and sign/zero extension.
// Purely combinational; off selects the starting byte lane.
module mem_lsu_ldext
    import mem_lsu_pkg::*;
(
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [2:0]        off_i,
    input  logic [2:0]        funct3_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] lane;

    assign lane = rdata_i >> {off_i, 3'b000};

    always_comb begin
        data_o = lane;
        unique case (funct3_i)
            F3_B:    data_o = {{56{lane[7]}}, lane[7:0]};
            F3_H:    data_o = {{48{lane[15]}}, lane[15:0]};
            F3_W:    data_o = {{32{lane[31]}}, lane[31:0]};
            F3_BU:   data_o = {56'd0, lane[7:0]};
            F3_HU:   data_o = {48'd0, lane[15:0]};
            F3_WU:   data_o = {32'd0, lane[31:0]};
            default: data_o = lane;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage: issues loads/stores on the dmem bus, stalls upstream.
// Optional misaligned-access trap: define MEM_LSU_MISALIGN_CHK_EN.
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_lsu_valid_i,
    input  logic                 mem_lsu_mem_read_i,
    input  logic                 mem_lsu_mem_write_i,
    input  logic [2:0]           mem_lsu_funct3_i,
    input  logic [DATA_W-1:0]    mem_lsu_res_data_i,
    input  logic [DATA_W-1:0]    mem_lsu_rs2_data_i,
    input  logic                 mem_lsu_rd_en_i,
    input  logic [REG_IDX_W-1:0] mem_lsu_rd_index_i,
    output logic                 mem_lsu_stall_o,
    mem_lsu_if.master            dmem,
    output logic                 mem_lsu_wb_valid_o,
    output logic                 mem_lsu_wb_rd_en_o,
    output logic [REG_IDX_W-1:0] mem_lsu_wb_rd_index_o,
    output logic [DATA_W-1:0]    mem_lsu_wb_rd_data_o,
    output logic                 mem_lsu_misalign_o
);

    lsu_state_e state_q, state_d;

    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic [DATA_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [MASK_W-1:0]    wmask_q, wmask_d;

    logic [2:0]           f3_q, f3_d;
    logic [2:0]           off_q, off_d;
    logic                 lrd_en_q, lrd_en_d;
    logic [REG_IDX_W-1:0] lrd_idx_q, lrd_idx_d;

    logic                 wb_valid_q, wb_valid_d;
    logic                 wb_rd_en_q, wb_rd_en_d;
    logic [REG_IDX_W-1:0] wb_idx_q, wb_idx_d;
    logic [DATA_W-1:0]    wb_data_q, wb_data_d;
    logic                 misalign_q, misalign_d;

    logic                 mem_op;
    logic [2:0]           off;
    logic                 misaligned;
    logic [DATA_W-1:0]    ld_data;

    assign mem_op = mem_lsu_valid_i
                  & (mem_lsu_mem_read_i | mem_lsu_mem_write_i);
    assign off    = mem_lsu_res_data_i[2:0];

`ifdef MEM_LSU_MISALIGN_CHK_EN
    assign misaligned = is_misaligned(mem_lsu_funct3_i, off);
`else
    assign misaligned = 1'b0;
`endif

    mem_lsu_ldext u_ldext (
        .rdata_i  (dmem.rdata),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .data_o   (ld_data)
    );

    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        we_d            = we_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        wmask_d         = wmask_q;
        f3_d            = f3_q;
        off_d           = off_q;
        lrd_en_d        = lrd_en_q;
        lrd_idx_d       = lrd_idx_q;
        wb_valid_d      = 1'b0;
        wb_rd_en_d      = wb_rd_en_q;
        wb_idx_d        = wb_idx_q;
        wb_data_d       = wb_data_q;
        misalign_d      = 1'b0;
        mem_lsu_stall_o = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (mem_op && misaligned) begin
                    wb_valid_d = 1'b1;
                    wb_rd_en_d = 1'b0;
                    wb_idx_d   = mem_lsu_rd_index_i;
                    wb_data_d  = mem_lsu_res_data_i;
                    misalign_d = 1'b1;
                end else if (mem_op) begin
                    mem_lsu_stall_o = 1'b1;
                    state_d   = ST_REQ;
                    req_d     = 1'b1;
                    we_d      = mem_lsu_mem_write_i;
                    addr_d    = {mem_lsu_res_data_i[DATA_W-1:3], 3'b000};
                    wdata_d   = mem_lsu_rs2_data_i << {off, 3'b000};
                    wmask_d   = size_mask(mem_lsu_funct3_i, off);
                    f3_d      = mem_lsu_funct3_i;
                    off_d     = off;
                    lrd_en_d  = mem_lsu_rd_en_i;
                    lrd_idx_d = mem_lsu_rd_index_i;
                end else if (mem_lsu_valid_i) begin
                    wb_valid_d = 1'b1;
                    wb_rd_en_d = mem_lsu_rd_en_i;
                    wb_idx_d   = mem_lsu_rd_index_i;
                    wb_data_d  = mem_lsu_res_data_i;
                end
            end
            ST_REQ: begin
                mem_lsu_stall_o = ~(dmem.gnt & we_q);
                if (dmem.gnt) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    if (we_q) begin
                        state_d    = ST_IDLE;
                        wb_valid_d = 1'b1;
                        wb_rd_en_d = 1'b0;
                        wb_idx_d   = lrd_idx_q;
                        wb_data_d  = '0;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                mem_lsu_stall_o = ~dmem.rvalid;
                if (dmem.rvalid) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_en_d = lrd_en_q;
                    wb_idx_d   = lrd_idx_q;
                    wb_data_d  = ld_data;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            lrd_en_q   <= 1'b0;
            lrd_idx_q  <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_en_q <= 1'b0;
            wb_idx_q   <= '0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            lrd_en_q   <= lrd_en_d;
            lrd_idx_q  <= lrd_idx_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_en_q <= wb_rd_en_d;
            wb_idx_q   <= wb_idx_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
        end
    end

    assign dmem.req              = req_q;
    assign dmem.we               = we_q;
    assign dmem.addr             = addr_q;
    assign dmem.wdata            = wdata_q;
    assign dmem.wmask            = wmask_q;
    assign mem_lsu_wb_valid_o    = wb_valid_q;
    assign mem_lsu_wb_rd_en_o    = wb_rd_en_q;
    assign mem_lsu_wb_rd_index_o = wb_idx_q;
    assign mem_lsu_wb_rd_data_o  = wb_data_q;
    assign mem_lsu_misalign_o    = misalign_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed testbench for mem_lsu: ALU pass-through, loads, stores,
// bus wait states, misaligned access and reset mid-access.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic                 clk;
    logic                 rst;
    logic                 valid;
    logic                 rd;
    logic                 wr;
    logic [2:0]           f3;
    logic [DATA_W-1:0]    res;
    logic [DATA_W-1:0]    rs2;
    logic                 rd_en;
    logic [REG_IDX_W-1:0] rd_idx;
    logic                 stall;
    logic                 wb_valid;
    logic                 wb_rd_en;
    logic [REG_IDX_W-1:0] wb_idx;
    logic [DATA_W-1:0]    wb_data;
    logic                 misalign;

    int n_chk;
    int n_fail;

    mem_lsu_if dmem ();

    mem_lsu dut (
        .clk                   (clk),
        .rst                   (rst),
        .mem_lsu_valid_i       (valid),
        .mem_lsu_mem_read_i    (rd),
        .mem_lsu_mem_write_i   (wr),
        .mem_lsu_funct3_i      (f3),
        .mem_lsu_res_data_i    (res),
        .mem_lsu_rs2_data_i    (rs2),
        .mem_lsu_rd_en_i       (rd_en),
        .mem_lsu_rd_index_i    (rd_idx),
        .mem_lsu_stall_o       (stall),
        .dmem                  (dmem),
        .mem_lsu_wb_valid_o    (wb_valid),
        .mem_lsu_wb_rd_en_o    (wb_rd_en),
        .mem_lsu_wb_rd_index_o (wb_idx),
        .mem_lsu_wb_rd_data_o  (wb_data),
        .mem_lsu_misalign_o    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clr();
        valid = 1'b0;
        rd = 1'b0;
        wr = 1'b0;
        f3 = 3'b000;
        res = '0;
        rs2 = '0;
        rd_en = 1'b0;
        rd_idx = '0;
        dmem.gnt = 1'b0;
        dmem.rvalid = 1'b0;
        dmem.rdata = '0;
    endtask

    task automatic present(input logic r, input logic w,
                           input logic [2:0] fn,
                           input logic [63:0] a, input logic [63:0] d,
                           input logic en, input logic [4:0] idx);
        valid = 1'b1;
        rd = r;
        wr = w;
        f3 = fn;
        res = a;
        rs2 = d;
        rd_en = en;
        rd_idx = idx;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        clr();
        nxt();
        nxt();
        smp();
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_req", 64'(dmem.req), 64'd0);
        check("rst_addr", dmem.addr, 64'd0);
        check("rst_wmask", 64'(dmem.wmask), 64'd0);
        check("rst_misalign", 64'(misalign), 64'd0);
        nxt();
        rst = 1'b0;

        // ALU op
        nxt();
        present(1'b0, 1'b0, F3_D, 64'h1234, 64'd0, 1'b1, 5'd5);
        smp();
        check("alu_stall", 64'(stall), 64'd0);
        nxt();
        clr();
        smp();
        check("alu_wb_valid", 64'(wb_valid), 64'd1);
        check("alu_rd_en", 64'(wb_rd_en), 64'd1);
        check("alu_idx", 64'(wb_idx), 64'd5);
        check("alu_data", wb_data, 64'h1234);
        check("alu_req", 64'(dmem.req), 64'd0);
        nxt();
        smp();
        check("alu_bubble", 64'(wb_valid), 64'd0);

        // LB 0x1003
        nxt();
        present(1'b1, 1'b0, F3_B, 64'h1003, 64'd0, 1'b1, 5'd9);
        smp();
        check("lb_stall0", 64'(stall), 64'd1);
        check("lb_req0", 64'(dmem.req), 64'd0);
        nxt();
        dmem.gnt = 1'b1;
        smp();
        check("lb_req1", 64'(dmem.req), 64'd1);
        check("lb_addr", dmem.addr, 64'h1000);
        check("lb_we", 64'(dmem.we), 64'd0);
        check("lb_stall1", 64'(stall), 64'd1);
        nxt();
        dmem.gnt = 1'b0;
        dmem.rvalid = 1'b1;
        dmem.rdata = 64'h00000000_80000000;
        smp();
        check("lb_stall2", 64'(stall), 64'd0);
        check("lb_req2", 64'(dmem.req), 64'd0);
        check("lb_wb_early", 64'(wb_valid), 64'd0);
        nxt();
        clr();
        smp();
        check("lb_wb_valid", 64'(wb_valid), 64'd1);
        check("lb_data", wb_data, 64'hFFFFFFFF_FFFFFF80);
        check("lb_idx", 64'(wb_idx), 64'd9);
        check("lb_rd_en", 64'(wb_rd_en), 64'd1);

        // SW 0x2004
        nxt();
        present(1'b0, 1'b1, F3_W, 64'h2004, 64'hDEADBEEF, 1'b1, 5'd7);
        smp();
        check("sw_stall0", 64'(stall), 64'd1);
        nxt();
        dmem.gnt = 1'b1;
        smp();
        check("sw_req", 64'(dmem.req), 64'd1);
        check("sw_we", 64'(dmem.we), 64'd1);
        check("sw_addr", dmem.addr, 64'h2000);
        check("sw_wmask", 64'(dmem.wmask), 64'hF0);
        check("sw_wdata", dmem.wdata, 64'hDEADBEEF_00000000);
        check("sw_stall1", 64'(stall), 64'd0);
        nxt();
        clr();
        smp();
        check("sw_wb_valid", 64'(wb_valid), 64'd1);
        check("sw_rd_en", 64'(wb_rd_en), 64'd0);
        check("sw_req_drop", 64'(dmem.req), 64'd0);

        // LD with gnt held low for three cycles
        nxt();
        present(1'b1, 1'b0, F3_D, 64'h4008, 64'd0, 1'b1, 5'd12);
        smp();
        for (int i = 0; i < 3; i++) begin
            nxt();
            smp();
            check("ld_wait_req", 64'(dmem.req), 64'd1);
            check("ld_wait_stall", 64'(stall), 64'd1);
            check("ld_wait_wb", 64'(wb_valid), 64'd0);
        end
        nxt();
        dmem.gnt = 1'b1;
        smp();
        check("ld_gnt_stall", 64'(stall), 64'd1);
        nxt();
        dmem.gnt = 1'b0;
        smp();
        check("ld_wait2_stall", 64'(stall), 64'd1);
        check("ld_wait2_req", 64'(dmem.req), 64'd0);
        nxt();
        dmem.rvalid = 1'b1;
        dmem.rdata = 64'h01234567_89ABCDEF;
        smp();
        check("ld_rv_stall", 64'(stall), 64'd0);
        nxt();
        clr();
        smp();
        check("ld_wb_valid", 64'(wb_valid), 64'd1);
        check("ld_data", wb_data, 64'h01234567_89ABCDEF);
        nxt();
        smp();
        check("ld_one_shot", 64'(wb_valid), 64'd0);

        // LH 0x3001
        nxt();
        present(1'b1, 1'b0, F3_H, 64'h3001, 64'd0, 1'b1, 5'd3);
        smp();
`ifdef MEM_LSU_MISALIGN_CHK_EN
        check("lh_mis_stall", 64'(stall), 64'd0);
        nxt();
        clr();
        smp();
        check("lh_mis_flag", 64'(misalign), 64'd1);
        check("lh_mis_wb", 64'(wb_valid), 64'd1);
        check("lh_mis_rd_en", 64'(wb_rd_en), 64'd0);
        check("lh_mis_data", wb_data, 64'h3001);
        check("lh_mis_req", 64'(dmem.req), 64'd0);
        nxt();
        smp();
        check("lh_mis_pulse", 64'(misalign), 64'd0);
`else
        check("lh_stall", 64'(stall), 64'd1);
        nxt();
        dmem.gnt = 1'b1;
        smp();
        check("lh_req", 64'(dmem.req), 64'd1);
        check("lh_wmask", 64'(dmem.wmask), 64'h06);
        check("lh_addr", dmem.addr, 64'h3000);
        nxt();
        dmem.gnt = 1'b0;
        dmem.rvalid = 1'b1;
        dmem.rdata = 64'h00000000_00800100;
        smp();
        nxt();
        clr();
        smp();
        check("lh_wb_valid", 64'(wb_valid), 64'd1);
        check("lh_data", wb_data, 64'hFFFFFFFF_FFFF8001);
        check("lh_misalign", 64'(misalign), 64'd0);
`endif

        // Reset while waiting for rvalid
        nxt();
        present(1'b1, 1'b0, F3_W, 64'h5000, 64'd0, 1'b1, 5'd4);
        smp();
        nxt();
        dmem.gnt = 1'b1;
        smp();
        nxt();
        dmem.gnt = 1'b0;
        smp();
        check("rw_wait_stall", 64'(stall), 64'd1);
        nxt();
        clr();
        rst = 1'b1;
        smp();
        nxt();
        rst = 1'b0;
        dmem.rvalid = 1'b1;
        dmem.rdata = 64'hFFFFFFFF_FFFFFFFF;
        smp();
        check("rw_req", 64'(dmem.req), 64'd0);
        check("rw_stall", 64'(stall), 64'd0);
        check("rw_addr", dmem.addr, 64'd0);
        nxt();
        dmem.rvalid = 1'b0;
        smp();
        check("rw_wb_valid", 64'(wb_valid), 64'd0);
        check("rw_wb_data", wb_data, 64'd0);
        check("rw_wmask", 64'(dmem.wmask), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
